// File: rtl/sfp_row_seq.sv
// sfp_row_seq: per-core sequencer for one SFP normalisation row.
// Each row goes through: FIFO pop, accumulate, a sum handshake with the peer
// core, a divide, and an output write. A bypass pass pops and writes only.
// Optional feature macro: SFP_SEQ_TIMEOUT_EN adds a watchdog on the SYNC and
// DIV waits. When it fires, err is set and stays set until reset.
// Every output comes from a flop that is loaded from the next-state
// decode. Each output therefore lines up with the state it belongs to, and
// no path runs combinationally from an input to an output.
module sfp_row_seq #(
    parameter int ROWS     = 8,
    parameter int ADDR_W   = 4,
    parameter int ACC_LAT  = 3,
    parameter int NORM_LAT = 2,
    parameter int TMO      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bypass,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic              acc,
    output logic              div,
    output logic              pass_through,
    output logic              row_clr,
    output logic              sum_rdy,
    input  logic              peer_sum_rdy,
    input  logic              sfp_valid,
    output logic              out_wr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ACC   = 3'd2,
        ST_SYNC  = 3'd3,
        ST_NORM  = 3'd4,
        ST_DIV   = 3'd5,
        ST_WRITE = 3'd6,
        ST_CLR   = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    // acc is held for ACC_LAT+1 cycles: the FIFO read cycle plus the adder tree.
    localparam logic [7:0]        ACC_END  = 8'(ACC_LAT);
    localparam logic [7:0]        NORM_END = 8'(NORM_LAT - 1);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   row_r, row_s;
    logic                bypass_r, bypass_s;
    logic                err_r, err_s;
    logic [7:0]          phase_r;
    logic                done_s, rd_s;
    logic                tmo_hit_s;

    logic                ofifo_rd_r, acc_r, div_r, pass_r, clr_r, sum_rdy_r;
    logic                out_wr_r, busy_r, done_r;
    logic [ADDR_W-1:0]   out_addr_r;

`ifdef SFP_SEQ_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TMO) + 1;
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO - 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Count the cycles spent waiting in SYNC or DIV. The count restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_s != state_r) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_SYNC) || (state_r == ST_DIV)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == TMO_END);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Count the cycles spent in the current state. ACC and NORM use this count to time their length.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= 8'd0;
        end else if (state_s != state_r) begin
            phase_r <= 8'd0;
        end else begin
            phase_r <= phase_r + 8'd1;
        end
    end

    // State register and pass context: row counter, latched bypass, sticky err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            row_r    <= {ADDR_W{1'b0}};
            bypass_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            row_r    <= row_s;
            bypass_r <= bypass_s;
            err_r    <= err_s;
        end
    end

    // Next-state logic, and the pulses that depend on the transition taken.
    always_comb begin
        state_s  = state_r;
        row_s    = row_r;
        bypass_s = bypass_r;
        err_s    = err_r;
        done_s   = 1'b0;
        rd_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    bypass_s = bypass;
                    row_s    = {ADDR_W{1'b0}};
                    state_s  = ST_FETCH;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (ofifo_valid) begin
                    rd_s    = 1'b1;
                    state_s = bypass_r ? ST_WRITE : ST_ACC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_ACC: begin
                if (phase_r == ACC_END) begin
                    state_s = ST_SYNC;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_SYNC: begin
                if (peer_sum_rdy) begin
                    state_s = ST_NORM;
                end else if (tmo_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_NORM: begin
                if (phase_r == NORM_END) begin
                    state_s = ST_DIV;
                end else begin
                    state_s = ST_NORM;
                end
            end
            ST_DIV: begin
                if (sfp_valid) begin
                    state_s = ST_WRITE;
                end else if (tmo_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_WRITE: begin
                if (!bypass_r) begin
                    state_s = ST_CLR;
                end else if (row_r == LAST_ROW) begin
                    done_s  = 1'b1;
                    row_s   = {ADDR_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    row_s   = row_r + ADDR_W'(1);
                    state_s = ST_FETCH;
                end
            end
            ST_CLR: begin
                if (row_r == LAST_ROW) begin
                    done_s  = 1'b1;
                    row_s   = {ADDR_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    row_s   = row_r + ADDR_W'(1);
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output flops. Each one is loaded from the decoded next state, so it is high in the same cycle as its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ofifo_rd_r <= 1'b0;
            acc_r      <= 1'b0;
            div_r      <= 1'b0;
            pass_r     <= 1'b0;
            clr_r      <= 1'b0;
            sum_rdy_r  <= 1'b0;
            out_wr_r   <= 1'b0;
            out_addr_r <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            ofifo_rd_r <= rd_s;
            acc_r      <= (state_s == ST_ACC);
            div_r      <= (state_s == ST_DIV);
            pass_r     <= (state_s != ST_IDLE) && bypass_s;
            clr_r      <= (state_s == ST_CLR);
            sum_rdy_r  <= (state_s == ST_SYNC);
            out_wr_r   <= (state_s == ST_WRITE);
            out_addr_r <= (state_s == ST_WRITE) ? row_s : {ADDR_W{1'b0}};
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= done_s;
        end
    end

    assign ofifo_rd     = ofifo_rd_r;
    assign acc          = acc_r;
    assign div          = div_r;
    assign pass_through = pass_r;
    assign row_clr      = clr_r;
    assign sum_rdy      = sum_rdy_r;
    assign out_wr       = out_wr_r;
    assign out_addr     = out_addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_sfp_row_seq.sv
// tb_sfp_row_seq: self-checking bench for sfp_row_seq.
// The stimulus pushes the expected write addresses and done events into a queue.
// A negedge monitor pops an entry and compares it each time the DUT writes or pulses done.
module tb_sfp_row_seq;
    logic       clk = 1'b0;
    logic       reset, start, bypass, ofifo_valid, peer_sum_rdy;
    logic       sfp_valid = 1'b0;
    logic       ofifo_rd, acc, div, pass_through, row_clr, sum_rdy;
    logic       out_wr, busy, done, err;
    logic [3:0] out_addr;

    localparam int DONE_TAG = 100;

    int   checks = 0, errors = 0;
    int   exp_q[$];
    logic exp_bypass = 1'b0;
    int   exp_acc = 0, exp_div = 0, exp_period = 0;
    int   cyc = 0, last_wr = -1, acc_c = 0, div_c = 0, clr_tot = 0, pt_bad = 0;
    int   div_cyc = 0;
    bit   sfp_hang = 1'b0;

    sfp_row_seq dut (
        .clk(clk), .reset(reset), .start(start), .bypass(bypass),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .acc(acc), .div(div),
        .pass_through(pass_through), .row_clr(row_clr), .sum_rdy(sum_rdy),
        .peer_sum_rdy(peer_sum_rdy), .sfp_valid(sfp_valid), .out_wr(out_wr),
        .out_addr(out_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SFP stand-in: raises sfp_valid in the 5th DIV cycle, or never when sfp_hang is set.
    always @(negedge clk) begin
        if (div && !sfp_hang) div_cyc = div_cyc + 1;
        else div_cyc = 0;
        sfp_valid = (div_cyc == 5);
    end

    // Monitor: scoreboard for writes and done, per-row acc/div counts, row period, pass_through.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            acc_c = 0; div_c = 0; last_wr = -1;
        end else begin
            if (acc) acc_c = acc_c + 1;
            if (div) div_c = div_c + 1;
            if (row_clr) clr_tot = clr_tot + 1;
            if (pass_through !== (busy & exp_bypass)) pt_bad = pt_bad + 1;
            if (out_wr) begin
                check("wr_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("wr_addr", int'(out_addr), exp_q.pop_front());
                check("acc_cycles", acc_c, exp_acc);
                check("div_cycles", div_c, exp_div);
                if (exp_period != 0 && last_wr >= 0) check("row_period", cyc - last_wr, exp_period);
                last_wr = cyc; acc_c = 0; div_c = 0;
            end
            if (done) begin
                check("done_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("done_order", exp_q.pop_front(), DONE_TAG);
            end
        end
    end

    task automatic push_rows(input int n, input bit with_done);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
        if (with_done) exp_q.push_back(DONE_TAG);
        last_wr = -1;
        clr_tot = 0;
        pt_bad  = 0;
    endtask

    task automatic pulse_start(input bit byp);
        exp_bypass = byp;
        start  = 1'b1;
        bypass = byp;
        @(negedge clk);
        start  = 1'b0;
        bypass = ~byp;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, int'(busy), 0);
        @(negedge clk);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_pass_through"}, pt_bad, 0);
    endtask

    task automatic wait_wr_addr(input string name, input int a);
        int n = 0;
        while (!(out_wr && out_addr == 4'(a)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_write"}, int'(out_wr), 1);
    endtask

    task automatic wait_div(input string name);
        int n = 0;
        while (!div && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_div"}, int'(div), 1);
    endtask

    initial begin
        int k, bad;
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k, bad;
        reset = 1'b1; start = 1'b0; bypass = 1'b0;
        ofifo_valid = 1'b1; peer_sum_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_outs", int'({ofifo_rd, acc, div, pass_through, row_clr, sum_rdy, out_wr, done, err}), 0);
        check("rst_addr", int'(out_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: a full normal pass. A second start, with bypass=1, is issued mid-pass.
        exp_acc = 4; exp_div = 5; exp_period = 15;
        push_rows(8, 1'b1);
        pulse_start(1'b0);
        repeat (30) @(negedge clk);
        start = 1'b1; bypass = 1'b1;
        @(negedge clk);
        start = 1'b0; bypass = 1'b0;
        wait_idle("t1", 400);
        check("t1_row_clr_total", clr_tot, 8);

        // T2: bypass pass. The bypass input changes after start.
        exp_acc = 0; exp_div = 0; exp_period = 2;
        push_rows(8, 1'b1);
        pulse_start(1'b1);
        wait_idle("t2", 100);
        check("t2_row_clr_total", clr_tot, 0);

        // T3: peer sum held back for 20 cycles in SYNC.
        exp_acc = 4; exp_div = 5; exp_period = 15;
        peer_sum_rdy = 1'b0;
        push_rows(8, 1'b1);
        pulse_start(1'b0);
        k = 0;
        while (!sum_rdy && k < 50) begin @(negedge clk); k++; end
        check("t3_sync_reached", int'(sum_rdy), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(sum_rdy && !div)) bad++;
            @(negedge clk);
        end
        check("t3_hold_in_sync", bad, 0);
        peer_sum_rdy = 1'b1;
        k = 0;
        while (!div && k < 20) begin @(negedge clk); k++; end
        check("t3_div_latency", k, 3);
        wait_idle("t3", 400);
        check("t3_row_clr_total", clr_tot, 8);

        // T4: FIFO runs empty for 10 cycles just before row 3.
        exp_period = 0;
        push_rows(8, 1'b1);
        pulse_start(1'b0);
        wait_wr_addr("t4", 2);
        ofifo_valid = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (ofifo_rd || acc || div || !busy) bad++;
        end
        check("t4_fetch_stall", bad, 0);
        ofifo_valid = 1'b1;
        wait_idle("t4", 400);

        // T5: reset in the middle of DIV for row 5, then a fresh pass.
        exp_period = 15;
        push_rows(5, 1'b0);
        pulse_start(1'b0);
        wait_wr_addr("t5", 4);
        @(negedge clk);
        wait_div("t5");
        reset = 1'b1;
        @(negedge clk);
        check("t5_outs_zero", int'({ofifo_rd, acc, div, pass_through, row_clr, sum_rdy, out_wr, busy, done, out_addr}), 0);
        @(negedge clk);
        reset = 1'b0;
        check("t5_rows_before_reset", exp_q.size(), 0);
        push_rows(8, 1'b1);
        pulse_start(1'b0);
        wait_idle("t5_restart", 400);

`ifdef SFP_SEQ_TIMEOUT_EN
        // T6: sfp_valid never arrives, so the watchdog fires.
        sfp_hang = 1'b1;
        push_rows(0, 1'b0);
        pulse_start(1'b0);
        wait_div("t6");
        k = 0;
        while (!err && k < 100) begin @(negedge clk); k++; end
        check("t6_err_latency", k, 64);
        check("t6_busy_low", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("t6_err_sticky", int'(err), 1);
        check("t6_no_write", exp_q.size(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_err_cleared", int'(err), 0);
        sfp_hang = 1'b0;
`else
        check("err_tied_low", int'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
